// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-bus arbiter between the fetch
// port and the memory-stage data port.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [3:0] FETCH_SEL = 4'hF;

endpackage

// File: rtl/mem_arb_req_latch.sv
// Holds the granted request (owner and bus fields) for the duration of one
// bus transaction; reloaded only on a grant.
module mem_arb_req_latch
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  owner_t            owner_in,
    input  logic              wr_in,
    input  logic [3:0]        sel_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output owner_t            owner,
    output logic              wr,
    output logic [3:0]        sel,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata
);

    owner_t            owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [3:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        owner_d = owner_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (load) begin
            owner_d = owner_in;
            wr_d    = wr_in;
            sel_d   = sel_in;
            addr_d  = addr_in;
            wdata_d = wdata_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_I;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign owner = owner_q;
    assign wr    = wr_q;
    assign sel   = sel_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-like bus between the fetch port
// and the data port; data has priority, results are registered per owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_stall,
    input  logic              flush,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              m_req,
    output logic              m_wr,
    output logic [3:0]        m_sel,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata,
    output state_t            dbg_state
);

    // Handshakes: a requester holds req (and its fields) until it sees its
    // one-cycle ready pulse; the bus holds m_req until m_addr_ok, then
    // m_data_ok marks completion (it may coincide with m_addr_ok).

    state_t            state_q, state_d;
    logic              discard_q, discard_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              load;
    owner_t            ld_owner;
    logic              ld_wr;
    logic [3:0]        ld_sel;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    owner_t            owner;

    logic              d_win;
    logic              i_win;
    logic              complete;
    logic              fetch_flush;
    logic              discard_now;
    logic              i_done;
    logic              d_done;

    // A requester still shows its old req in its ready cycle; masking with
    // ready keeps that stale req from being granted a second time.
    assign d_win       = d_req & ~d_ready_q;
    assign i_win       = i_req & ~i_ready_q & ~flush;
    assign fetch_flush = flush & (owner == OWN_I) & (state_q != IDLE);
    assign discard_now = discard_q | fetch_flush;

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        ld_owner  = OWN_D;
        ld_wr     = 1'b0;
        ld_sel    = '0;
        ld_addr   = '0;
        ld_wdata  = '0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_win) begin
                    load     = 1'b1;
                    ld_owner = OWN_D;
                    ld_wr    = d_wr;
                    ld_sel   = d_sel;
                    ld_addr  = d_addr;
                    ld_wdata = d_wdata;
                    state_d  = REQ;
                end else if (i_win) begin
                    // Fetch carries no store data; wdata is latched as zero.
                    load     = 1'b1;
                    ld_owner = OWN_I;
                    ld_wr    = 1'b0;
                    ld_sel   = FETCH_SEL;
                    ld_addr  = i_addr;
                    ld_wdata = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (m_data_ok) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        discard_d = discard_now;
        if (complete || state_q == IDLE) begin
            discard_d = 1'b0;
        end
        i_done    = complete & (owner == OWN_I) & ~discard_now;
        d_done    = complete & (owner == OWN_D);
        i_ready_d = i_done;
        d_ready_d = d_done;
        i_rdata_d = i_done ? m_rdata : i_rdata_q;
        d_rdata_d = d_done ? m_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    mem_arb_req_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_latch (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .owner_in (ld_owner),
        .wr_in    (ld_wr),
        .sel_in   (ld_sel),
        .addr_in  (ld_addr),
        .wdata_in (ld_wdata),
        .owner    (owner),
        .wr       (m_wr),
        .sel      (m_sel),
        .addr     (m_addr),
        .wdata    (m_wdata)
    );

    assign m_req     = (state_q == REQ);
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_stall   = i_req & ~i_ready_q;
    assign d_stall   = d_req & ~d_ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle directed bench for mem_arbiter: each record gives one cycle's
// inputs and the outputs expected in that same cycle.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        i_stall;
    logic        flush = 1'b0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [3:0]  d_sel = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_stall;
    logic        m_req;
    logic        m_wr;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok = 1'b0;
    logic        m_data_ok = 1'b0;
    logic [31:0] m_rdata = '0;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .i_stall   (i_stall),
        .flush     (flush),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_sel     (d_sel),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .d_stall   (d_stall),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_sel     (m_sel),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        flush;
        logic        d_req;
        logic        d_wr;
        logic [3:0]  d_sel;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        aok;
        logic        dok;
        logic [31:0] m_rdata;
    } in_t;

    typedef struct {
        logic        m_req;
        logic        m_wr;
        logic [3:0]  m_sel;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic        i_ready;
        logic [31:0] i_rdata;
        logic        i_stall;
        logic        d_ready;
        logic [31:0] d_rdata;
        logic        d_stall;
    } exp_t;

    typedef struct {
        string tag;
        in_t   i;
        exp_t  e;
    } vec_t;

    vec_t vecs[$];

    function automatic in_t vin(input logic [31:0] r, input logic [31:0] ireq, input logic [31:0] iaddr,
                                input logic [31:0] fl, input logic [31:0] dreq, input logic [31:0] dwr,
                                input logic [31:0] dsel, input logic [31:0] daddr, input logic [31:0] dwdata,
                                input logic [31:0] aok, input logic [31:0] dok, input logic [31:0] rdata);
        in_t v;
        v.rst     = r[0];
        v.i_req   = ireq[0];
        v.i_addr  = iaddr;
        v.flush   = fl[0];
        v.d_req   = dreq[0];
        v.d_wr    = dwr[0];
        v.d_sel   = dsel[3:0];
        v.d_addr  = daddr;
        v.d_wdata = dwdata;
        v.aok     = aok[0];
        v.dok     = dok[0];
        v.m_rdata = rdata;
        return v;
    endfunction

    function automatic exp_t vex(input logic [31:0] mreq, input logic [31:0] mwr, input logic [31:0] msel,
                                 input logic [31:0] maddr, input logic [31:0] mwdata, input logic [31:0] irdy,
                                 input logic [31:0] irdata, input logic [31:0] istall, input logic [31:0] drdy,
                                 input logic [31:0] drdata, input logic [31:0] dstall);
        exp_t e;
        e.m_req   = mreq[0];
        e.m_wr    = mwr[0];
        e.m_sel   = msel[3:0];
        e.m_addr  = maddr;
        e.m_wdata = mwdata;
        e.i_ready = irdy[0];
        e.i_rdata = irdata;
        e.i_stall = istall[0];
        e.d_ready = drdy[0];
        e.d_rdata = drdata;
        e.d_stall = dstall[0];
        return e;
    endfunction

    task automatic add(input string tag, input in_t i, input exp_t e);
        vec_t v;
        v.tag = tag;
        v.i   = i;
        v.e   = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s got %h expected %h", tag, name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, check on the falling edge.
    task automatic apply(input string tag, input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        rst       = i.rst;
        i_req     = i.i_req;
        i_addr    = i.i_addr;
        flush     = i.flush;
        d_req     = i.d_req;
        d_wr      = i.d_wr;
        d_sel     = i.d_sel;
        d_addr    = i.d_addr;
        d_wdata   = i.d_wdata;
        m_addr_ok = i.aok;
        m_data_ok = i.dok;
        m_rdata   = i.m_rdata;
        @(negedge clk);
        chk(tag, "m_req",   32'(m_req),   32'(e.m_req));
        chk(tag, "m_wr",    32'(m_wr),    32'(e.m_wr));
        chk(tag, "m_sel",   32'(m_sel),   32'(e.m_sel));
        chk(tag, "m_addr",  m_addr,       e.m_addr);
        chk(tag, "m_wdata", m_wdata,      e.m_wdata);
        chk(tag, "i_ready", 32'(i_ready), 32'(e.i_ready));
        chk(tag, "i_rdata", i_rdata,      e.i_rdata);
        chk(tag, "i_stall", 32'(i_stall), 32'(e.i_stall));
        chk(tag, "d_ready", 32'(d_ready), 32'(e.d_ready));
        chk(tag, "d_rdata", d_rdata,      e.d_rdata);
        chk(tag, "d_stall", 32'(d_stall), 32'(e.d_stall));
    endtask

    initial begin
        // Reset values; stalls follow the req inputs even in reset.
        add("rst0", vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("rst1", vin(1, 1, 'h40, 0, 1, 1, 'h3, 'h8, 'h9, 1, 1, 1), vex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        // Single fetch, addr_ok in cycle 1, data_ok in cycle 3.
        add("a0", vin(0, 1, 'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add("a1", vin(0, 1, 'hBFC00000, 0, 0, 0, 0, 0, 0, 1, 0, 0), vex(1, 0, 'hF, 'hBFC00000, 0, 0, 0, 1, 0, 0, 0));
        add("a2", vin(0, 1, 'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'hBFC00000, 0, 0, 0, 1, 0, 0, 0));
        add("a3", vin(0, 1, 'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 1, 'h24080001), vex(0, 0, 'hF, 'hBFC00000, 0, 0, 0, 1, 0, 0, 0));
        add("a4", vin(0, 1, 'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'hBFC00000, 0, 1, 'h24080001, 0, 0, 0, 0));
        add("a5", vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'hBFC00000, 0, 0, 'h24080001, 0, 0, 0, 0));
        // Simultaneous fetch and store: store first, fetch granted in the d_ready cycle.
        add("b0", vin(0, 1, 'h100, 0, 1, 1, 'h3, 'h10, 'hABCD, 0, 0, 0), vex(0, 0, 'hF, 'hBFC00000, 0, 0, 'h24080001, 1, 0, 0, 1));
        add("b1", vin(0, 1, 'h100, 0, 1, 1, 'h3, 'h10, 'hABCD, 1, 1, 0), vex(1, 1, 'h3, 'h10, 'hABCD, 0, 'h24080001, 1, 0, 0, 1));
        add("b2", vin(0, 1, 'h100, 0, 1, 1, 'h3, 'h10, 'hABCD, 0, 0, 0), vex(0, 1, 'h3, 'h10, 'hABCD, 0, 'h24080001, 1, 1, 0, 0));
        add("b3", vin(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0), vex(1, 0, 'hF, 'h100, 0, 0, 'h24080001, 1, 0, 0, 0));
        add("b4", vin(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 1, 'h11112222), vex(0, 0, 'hF, 'h100, 0, 0, 'h24080001, 1, 0, 0, 0));
        add("b5", vin(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h100, 0, 1, 'h11112222, 0, 0, 0, 0));
        add("b6", vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h100, 0, 0, 'h11112222, 0, 0, 0, 0));
        // Zero-wait bus: one ready per request, no re-grant of the held req.
        add("c0", vin(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h100, 0, 0, 'h11112222, 1, 0, 0, 0));
        add("c1", vin(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 1, 1, 'hAAAA0001), vex(1, 0, 'hF, 'h200, 0, 0, 'h11112222, 1, 0, 0, 0));
        add("c2", vin(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h200, 0, 1, 'hAAAA0001, 0, 0, 0, 0));
        add("c3", vin(0, 1, 'h204, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h200, 0, 0, 'hAAAA0001, 1, 0, 0, 0));
        add("c4", vin(0, 1, 'h204, 0, 0, 0, 0, 0, 0, 1, 1, 'hAAAA0002), vex(1, 0, 'hF, 'h204, 0, 0, 'hAAAA0001, 1, 0, 0, 0));
        add("c5", vin(0, 1, 'h204, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h204, 0, 1, 'hAAAA0002, 0, 0, 0, 0));
        add("c6", vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h204, 0, 0, 'hAAAA0002, 0, 0, 0, 0));
        // Load 0x20 then a store; bus keeps DEADBEEF on m_rdata during the store.
        add("d0", vin(0, 0, 0, 0, 1, 0, 'hF, 'h20, 0, 0, 0, 0), vex(0, 0, 'hF, 'h204, 0, 0, 'hAAAA0002, 0, 0, 0, 1));
        add("d1", vin(0, 0, 0, 0, 1, 0, 'hF, 'h20, 0, 1, 0, 0), vex(1, 0, 'hF, 'h20, 0, 0, 'hAAAA0002, 0, 0, 0, 1));
        add("d2", vin(0, 0, 0, 0, 1, 0, 'hF, 'h20, 0, 0, 1, 'hDEADBEEF), vex(0, 0, 'hF, 'h20, 0, 0, 'hAAAA0002, 0, 0, 0, 1));
        add("d3", vin(0, 0, 0, 0, 1, 0, 'hF, 'h20, 0, 0, 0, 0), vex(0, 0, 'hF, 'h20, 0, 0, 'hAAAA0002, 0, 1, 'hDEADBEEF, 0));
        add("d4", vin(0, 0, 0, 0, 1, 1, 'hF, 'h24, 'h12345678, 0, 0, 'hDEADBEEF), vex(0, 0, 'hF, 'h20, 0, 0, 'hAAAA0002, 0, 0, 'hDEADBEEF, 1));
        add("d5", vin(0, 0, 0, 0, 1, 1, 'hF, 'h24, 'h12345678, 1, 0, 'hDEADBEEF), vex(1, 1, 'hF, 'h24, 'h12345678, 0, 'hAAAA0002, 0, 0, 'hDEADBEEF, 1));
        add("d6", vin(0, 0, 0, 0, 1, 1, 'hF, 'h24, 'h12345678, 0, 1, 'hDEADBEEF), vex(0, 1, 'hF, 'h24, 'h12345678, 0, 'hAAAA0002, 0, 0, 'hDEADBEEF, 1));
        add("d7", vin(0, 0, 0, 0, 1, 1, 'hF, 'h24, 'h12345678, 0, 0, 0), vex(0, 1, 'hF, 'h24, 'h12345678, 0, 'hAAAA0002, 0, 1, 'hDEADBEEF, 0));
        add("d8", vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 1, 'hF, 'h24, 'h12345678, 0, 'hAAAA0002, 0, 0, 'hDEADBEEF, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k].tag, vecs[k].i, vecs[k].e);
        end

        // Flush while the fetch waits in RESP: bus completes, result dropped.
        apply("f0", vin(0, 1, 'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 1, 'hF, 'h24, 'h12345678, 0, 'hAAAA0002, 1, 0, 'hDEADBEEF, 0));
        apply("f1", vin(0, 1, 'h300, 0, 0, 0, 0, 0, 0, 1, 0, 0), vex(1, 0, 'hF, 'h300, 0, 0, 'hAAAA0002, 1, 0, 'hDEADBEEF, 0));
        apply("f2", vin(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h300, 0, 0, 'hAAAA0002, 0, 0, 'hDEADBEEF, 0));
        apply("f3", vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h99999999), vex(0, 0, 'hF, 'h300, 0, 0, 'hAAAA0002, 0, 0, 'hDEADBEEF, 0));
        apply("f4", vin(0, 1, 'hBFC00380, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h300, 0, 0, 'hAAAA0002, 1, 0, 'hDEADBEEF, 0));
        apply("f5", vin(0, 1, 'hBFC00380, 0, 0, 0, 0, 0, 0, 1, 1, 'h77770001), vex(1, 0, 'hF, 'hBFC00380, 0, 0, 'hAAAA0002, 1, 0, 'hDEADBEEF, 0));
        apply("f6", vin(0, 1, 'hBFC00380, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'hBFC00380, 0, 1, 'h77770001, 0, 0, 'hDEADBEEF, 0));
        apply("f7", vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'hBFC00380, 0, 0, 'h77770001, 0, 0, 'hDEADBEEF, 0));

        // Flush in the same cycle as completion still discards the fetch.
        apply("g0", vin(0, 1, 'h400, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'hBFC00380, 0, 0, 'h77770001, 1, 0, 'hDEADBEEF, 0));
        apply("g1", vin(0, 1, 'h400, 0, 0, 0, 0, 0, 0, 1, 0, 0), vex(1, 0, 'hF, 'h400, 0, 0, 'h77770001, 1, 0, 'hDEADBEEF, 0));
        apply("g2", vin(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 'h55555555), vex(0, 0, 'hF, 'h400, 0, 0, 'h77770001, 0, 0, 'hDEADBEEF, 0));
        apply("g3", vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h400, 0, 0, 'h77770001, 0, 0, 'hDEADBEEF, 0));

        // Flush does not touch a data transaction.
        apply("h0", vin(0, 0, 0, 1, 1, 0, 'hF, 'h28, 0, 0, 0, 0), vex(0, 0, 'hF, 'h400, 0, 0, 'h77770001, 0, 0, 'hDEADBEEF, 1));
        apply("h1", vin(0, 0, 0, 1, 1, 0, 'hF, 'h28, 0, 1, 1, 'h0BADF00D), vex(1, 0, 'hF, 'h28, 0, 0, 'h77770001, 0, 0, 'hDEADBEEF, 1));
        apply("h2", vin(0, 0, 0, 0, 1, 0, 'hF, 'h28, 0, 0, 0, 0), vex(0, 0, 'hF, 'h28, 0, 0, 'h77770001, 0, 1, 'h0BADF00D, 0));
        apply("h3", vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h28, 0, 0, 'h77770001, 0, 0, 'h0BADF00D, 0));

        // Reset while a fetch waits in RESP, then a fresh fetch.
        apply("s0", vin(0, 1, 'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h28, 0, 0, 'h77770001, 1, 0, 'h0BADF00D, 0));
        apply("s1", vin(0, 1, 'h500, 0, 0, 0, 0, 0, 0, 1, 0, 0), vex(1, 0, 'hF, 'h500, 0, 0, 'h77770001, 1, 0, 'h0BADF00D, 0));
        apply("s2", vin(0, 1, 'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h500, 0, 0, 'h77770001, 1, 0, 'h0BADF00D, 0));
        apply("s3", vin(1, 1, 'h500, 0, 0, 0, 0, 0, 0, 0, 1, 'h12121212), vex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        apply("s4", vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("s5", vin(0, 1, 'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        apply("s6", vin(0, 1, 'h600, 0, 0, 0, 0, 0, 0, 1, 1, 'h66), vex(1, 0, 'hF, 'h600, 0, 0, 0, 1, 0, 0, 0));
        apply("s7", vin(0, 1, 'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h600, 0, 1, 'h66, 0, 0, 0, 0));
        apply("s8", vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), vex(0, 0, 'hF, 'h600, 0, 0, 'h66, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single SRAM-like memory bus between the datapath's fetch port (PCF/InstF) and its memory-stage port (MemEn/Sel/ALUOutM/WriteDataM/ReadDataM). It runs at most one bus transaction at a time, gives the data port priority, and registers each result back to its owner. It also produces the stall requests that the hazard unit combines into StallF and StallM.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held until i_ready
- i_addr  in  ADDR_W  fetch address (PCF)
- i_rdata  out  DATA_W  fetched instruction (InstF)
- i_ready  out  1  one-cycle pulse when i_rdata is valid
- i_stall  out  1  fetch stall request to the hazard unit
- flush  in  1  exception flush; cancels the pending or in-flight fetch
- d_req  in  1  data request (MemEn); held until d_ready
- d_wr  in  1  1 = store
- d_sel  in  4  byte strobes (Sel)
- d_addr  in  ADDR_W  data address (ALUOutM)
- d_wdata  in  DATA_W  store data (WriteDataM)
- d_rdata  out  DATA_W  load data (ReadDataM)
- d_ready  out  1  one-cycle pulse at completion
- d_stall  out  1  memory-stage stall request
- m_req  out  1  bus request
- m_wr, m_sel, m_addr, m_wdata  out  1/4/ADDR_W/DATA_W  bus fields
- m_addr_ok  in  1  bus accepted the request
- m_data_ok  in  1  bus completed the transaction
- m_rdata  in  DATA_W  bus read data

## Operation
- FSM with three states:
  - IDLE: no transaction in progress.
  - REQ: m_req=1, bus fields driven from the latched request.
  - RESP: waiting for m_data_ok.
- Grant, evaluated only in IDLE:
  - d_req&~d_ready wins.
  - Otherwise i_req&~i_ready&~flush is granted.
  - On grant: latch owner, wr, sel, addr and wdata, then go to REQ.
  - A fetch is always latched with wr=0 and sel=4'hF.
- REQ:
  - m_addr_ok alone → go to RESP.
  - m_addr_ok&m_data_ok in the same cycle → complete directly and return to IDLE.
- RESP: on m_data_ok, complete and return to IDLE.
- Completion:
  - Capture m_rdata into the owner's rdata register (writes also capture it; the value is don't-care).
  - Pulse the owner's ready next cycle.
  - Return to IDLE.
- The ready-masking in the grant rule matters: in the cycle ready is high the requester still shows its old req. That req is never re-granted.
- flush:
  - While a fetch is in REQ or RESP, set the discard flag.
  - The bus transaction still runs to completion, since m_req is never withdrawn before m_addr_ok.
  - On completion, no i_ready pulse and i_rdata is not updated.
  - The flag clears on return to IDLE.
  - flush has no effect on data transactions.
- i_stall = i_req & ~i_ready. This also covers the cycles when fetch is waiting behind a data transaction.
- d_stall = d_req & ~d_ready.
- Both stalls are combinational.
- i_rdata and d_rdata hold their last value until that owner's next completion.

## Timing
- Reset values:
  - State IDLE, m_req=0.
  - m_wr, m_sel, m_addr, m_wdata = 0.
  - i_rdata, d_rdata = 0.
  - i_ready, d_ready = 0.
  - Discard flag = 0.
  - Stall outputs follow the req inputs.
- Best-case latency: req seen in cycle 0, m_req in cycle 1, addr_ok and data_ok in cycle 1, ready in cycle 2.
- Back-to-back: a new grant is possible in the ready cycle for the other owner, so m_req is high again in the cycle after ready.
- Simultaneous i_req and d_req: data goes first; fetch is granted in the cycle d_ready pulses.
- rst asserted mid-transaction: the FSM aborts immediately and m_req drops. The bus is assumed to be reset by the same rst.
- flush and completion in the same cycle: the fetch is discarded.

## Structure
- Package mem_arb_pkg holds:
  - state_t {IDLE, REQ, RESP}
  - owner_t {OWN_I, OWN_D}
  - the constant FETCH_SEL = 4'hF
- One natural sub-module, mem_arb_req_latch: holds the latched bus fields and owner, loaded on grant.

## Test plan
- Single fetch, i_addr=0xBFC00000, bus answers addr_ok in cycle 1 and data_ok in cycle 3 with 0x24080001 → i_ready pulses in cycle 4, i_rdata=0x24080001, i_stall high in cycles 0–3.
- i_req and d_req both raised in cycle 0, store d_addr=0x10, d_sel=4'b0011, d_wdata=0xABCD → bus sees the store first (m_wr=1, m_sel=0011), then the fetch. d_ready pulses before i_ready.
- Zero-wait bus (addr_ok&data_ok in the same cycle as m_req) → exactly one ready pulse per request. No duplicate grant in the ready cycle.
- flush in cycle 2 of a fetch in RESP → transaction completes on the bus, no i_ready, i_rdata unchanged. The next i_req is granted normally.
- Load d_addr=0x20 returns 0xDEADBEEF, followed by a store → d_rdata=0xDEADBEEF held through the store.
- rst pulsed while in RESP → m_req=0, all outputs at reset values next cycle. A fresh fetch completes normally afterwards.
